bs_gpr_seq: RTL and testbench
=============================

Name: bs_gpr_seq

Overview:
Sequencer for the two-register bit-serial GPR file (ry = addr 0, rx = addr 1). It accepts one instruction at a time over a valid/ready handshake. It then drives the GPR shift/write/address controls for WIDTH consecutive cycles, performing LD, CLR, ADD or SUB LSB-first through an internal one-bit serial adder. At completion it reports carry and zero flags.

Parameters:
WIDTH, 8, register width in bits; equals GPR length and the number of shift cycles per instruction.
CW, $clog2(WIDTH), bit-counter width (derived, not overridden).

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_valid  in  1  instruction offered
o_ready  out  1  sequencer can accept an instruction (IDLE only)
i_op  in  2  opcode: 00 LD, 01 CLR, 10 ADD, 11 SUB
i_dst  in  1  destination register address (0 = ry, 1 = rx); source is the other register
i_imm  in  WIDTH  immediate for LD
o_gpr_shift  out  1  to GPR shift control
o_gpr_write  out  1  to GPR write control
o_gpr_addr  out  1  to GPR rd_addr
o_gpr_data  out  1  to GPR serial data in
i_gpr_bit  in  1  GPR serial out (LSB of addressed register)
i_gpr_ry  in  WIDTH  GPR parallel ry
i_gpr_rx  in  WIDTH  GPR parallel rx
o_done  out  1  one-cycle pulse, instruction complete
o_carry  out  1  final carry (ADD carry-out; SUB 1 = no borrow); 0 for LD/CLR
o_zero  out  1  result was all zeros

Behaviour:
- Reset (async, i_rst=1): state IDLE, counter 0, carry 0, zero-accumulator 0.
  - Reset values: o_ready=1, o_done=0, o_carry=0, o_zero=0, o_gpr_shift=0, o_gpr_write=0, o_gpr_addr=0.
- States:
  - IDLE: o_ready=1. On i_valid&o_ready, latch op/dst/imm, clear counter, preset carry (0 for ADD, 1 for SUB), clear zero-accumulator, then go to RUN.
  - RUN: exactly WIDTH cycles. o_gpr_shift=1, o_gpr_addr=latched dst. Counter increments each cycle; on counter==WIDTH-1, go to DONE.
  - DONE: one cycle. o_done=1; o_carry/o_zero updated this cycle and held until the next instruction completes. Then go to IDLE.
- Bit k = counter value (k = 0..WIDTH-1) in RUN:
  - a = i_gpr_bit (dst bit k, since dst shifts right each cycle).
  - b = source[k] from the parallel bus of the non-dst register; the source does not shift.
  - LD: o_gpr_write=1, o_gpr_data=imm[k].
  - CLR: o_gpr_write=0, so the GPR shifts in 0.
  - ADD: o_gpr_write=1, o_gpr_data=a^b^c; c <= maj(a,b,c).
  - SUB: same as ADD with b inverted (two's complement, carry preset 1).
  - zero-accumulator |= written bit (0 for CLR).
- Result timing: after WIDTH shifts, the dst register holds the result with bit 0 in the LSB. It is visible on i_gpr_* from the DONE cycle.
- o_gpr_data is combinational from i_gpr_bit and the registered state. All other outputs decode directly from registered state.
- Outside RUN: o_gpr_shift=0, o_gpr_write=0, so the GPR holds.
- i_valid while not IDLE: ignored; no queuing. The instruction must be held until accepted.
- i_op/i_dst/i_imm changes after acceptance have no effect (latched).
- Reset mid-RUN: sequencer returns to IDLE immediately. The GPR has no reset, so the dst register is left partially shifted; software must reload it.
- Arithmetic is modulo 2^WIDTH; there is no overflow flag.

Decomposition:
- Package bs_pkg:
  - op_e enum (OP_LD=2'b00, OP_CLR=2'b01, OP_ADD=2'b10, OP_SUB=2'b11).
  - state_e enum (S_IDLE, S_RUN, S_DONE).
  - Default WIDTH constant.
- Sub-module bs_fa: serial full adder with carry flop. Ports: clk, async rst, enable, preset, preset value, a, b, invert_b; outputs sum and carry.

Test Plan:
- LD imm=0xA5 to dst=1 (rx) -> o_ready drops for 9 cycles; o_gpr_shift high exactly 8 cycles; rx=0xA5, ry unchanged; o_done pulses once; carry=0, zero=0.
- rx=0x3C, ry=0x5A, ADD dst=0 -> ry=0x96, rx=0x3C, carry=0, zero=0.
- ry=0xFF, rx=0x01, ADD dst=0 -> ry=0x00, carry=1, zero=1.
- rx=0x10, ry=0x10, SUB dst=1 -> rx=0x00, carry=1, zero=1. Then ry=0x01, SUB dst=1 (rx=0x00-0x01) -> rx=0xFF, carry=0, zero=0.
- Back-to-back: i_valid held high with a new op during RUN/DONE -> second instruction is accepted only on the IDLE cycle; each instruction produces exactly one o_done.
- Assert i_rst at RUN count 3 of an ADD -> all outputs return to reset values in the same cycle, with no o_done. A following CLR dst=0 yields ry=0x00, zero=1.

Source files
------------

// File: rtl/bs_pkg.sv
// Shared types and defaults for the bit-serial GPR sequencer.
package bs_pkg;

  localparam int unsigned BS_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_LD  = 2'b00,
    OP_CLR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/bs_fa.sv
// One-bit serial full adder; carry is held in a flop between bit cycles.
module bs_fa (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic preset,
  input  logic preset_val,
  input  logic a,
  input  logic b,
  input  logic inv_b,
  output logic sum,
  output logic carry
);

  logic bb;
  logic maj;

  always_comb begin
    bb  = b ^ inv_b;
    sum = a ^ bb ^ carry;
    maj = (a & bb) | (a & carry) | (bb & carry);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      carry <= 1'b0;
    else if (preset)
      carry <= preset_val;
    else if (en)
      carry <= maj;
  end

endmodule

// File: rtl/bs_gpr_seq.sv
// Sequencer driving the two-register bit-serial GPR file: one instruction
// is executed LSB-first over WIDTH shift cycles, then carry/zero are reported.
module bs_gpr_seq
  import bs_pkg::*;
#(
  parameter int unsigned WIDTH = BS_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic             i_dst,
  input  logic [WIDTH-1:0] i_imm,
  output logic             o_gpr_shift,
  output logic             o_gpr_write,
  output logic             o_gpr_addr,
  output logic             o_gpr_data,
  input  logic             i_gpr_bit,
  input  logic [WIDTH-1:0] i_gpr_ry,
  input  logic [WIDTH-1:0] i_gpr_rx,
  output logic             o_done,
  output logic             o_carry,
  output logic             o_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state, state_next;
  logic [CW-1:0]    cnt;
  op_e              op;
  logic             dst;
  logic [WIDTH-1:0] imm;
  logic             zacc;
  logic             flag_c, flag_z;

  logic accept, run, arith, last;
  logic src_bit, wbit, fa_sum, fa_carry;

  always_comb begin
    accept  = (state == S_IDLE) && i_valid;
    run     = (state == S_RUN);
    arith   = (op == OP_ADD) || (op == OP_SUB);
    last    = (cnt == CW'(WIDTH - 1));
    // Source is the non-destination register, read in parallel at bit cnt.
    src_bit = dst ? i_gpr_ry[cnt] : i_gpr_rx[cnt];
  end

  bs_fa u_fa (
    .clk        (i_clk),
    .rst        (i_rst),
    .en         (run && arith),
    .preset     (accept),
    .preset_val (i_op == OP_SUB),
    .a          (i_gpr_bit),
    .b          (src_bit),
    .inv_b      (op == OP_SUB),
    .sum        (fa_sum),
    .carry      (fa_carry)
  );

  always_comb begin
    wbit = 1'b0;
    unique case (op)
      OP_LD:   wbit = imm[cnt];
      OP_CLR:  wbit = 1'b0;
      default: wbit = fa_sum;
    endcase
  end

  always_comb begin
    state_next  = state;
    o_ready     = 1'b0;
    o_gpr_shift = 1'b0;
    o_gpr_write = 1'b0;
    o_gpr_addr  = 1'b0;
    o_gpr_data  = 1'b0;
    o_done      = 1'b0;
    o_carry     = flag_c;
    o_zero      = flag_z;
    unique case (state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_next = S_RUN;
      end
      S_RUN: begin
        o_gpr_shift = 1'b1;
        o_gpr_write = (op != OP_CLR);
        o_gpr_addr  = dst;
        o_gpr_data  = wbit;
        if (last) state_next = S_DONE;
      end
      S_DONE: begin
        // Final carry/zero are already settled in the adder and accumulator
        // flops, so they are shown directly this cycle and latched for later.
        o_done     = 1'b1;
        o_carry    = arith && fa_carry;
        o_zero     = !zacc;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op     <= OP_LD;
      dst    <= 1'b0;
      imm    <= '0;
      zacc   <= 1'b0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op   <= op_e'(i_op);
        dst  <= i_dst;
        imm  <= i_imm;
        cnt  <= '0;
        zacc <= 1'b0;
      end
      if (run) begin
        cnt  <= cnt + CW'(1);
        zacc <= zacc | wbit;
      end
      if (state == S_DONE) begin
        flag_c <= o_carry;
        flag_z <= o_zero;
      end
    end
  end

endmodule

// File: tb/tb_bs_gpr_seq.sv
// Bench for bs_gpr_seq: a behavioural GPR file plus an arithmetic result model.
module tb_bs_gpr_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  logic         ready;
  logic [1:0]   op = 2'b00;
  logic         dst = 1'b0;
  logic [W-1:0] imm = '0;
  logic         gshift, gwrite, gaddr, gdata, gbit;
  logic [W-1:0] ry, rx;
  logic         done, carry, zero;

  logic         ld = 1'b0;
  logic [W-1:0] ld_y = '0, ld_x = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bs_gpr_seq #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_op(op), .i_dst(dst), .i_imm(imm),
    .o_gpr_shift(gshift), .o_gpr_write(gwrite), .o_gpr_addr(gaddr),
    .o_gpr_data(gdata), .i_gpr_bit(gbit), .i_gpr_ry(ry), .i_gpr_rx(rx),
    .o_done(done), .o_carry(carry), .o_zero(zero)
  );

  // GPR file: no reset, shifts right with serial input at the MSB.
  always @(posedge clk) begin
    if (ld) begin
      ry <= ld_y;
      rx <= ld_x;
    end else if (gshift) begin
      if (gaddr) rx <= {gwrite ? gdata : 1'b0, rx[W-1:1]};
      else       ry <= {gwrite ? gdata : 1'b0, ry[W-1:1]};
    end
  end
  assign gbit = gaddr ? rx[0] : ry[0];

  function automatic void model(input logic [1:0] o, input logic [W-1:0] d,
                                input logic [W-1:0] s, input logic [W-1:0] im,
                                output logic [W-1:0] res, output logic c,
                                output logic z);
    int unsigned dv = d, sv = s;
    case (o)
      2'b00: begin res = im; c = 1'b0; end
      2'b01: begin res = '0; c = 1'b0; end
      2'b10: begin res = W'(dv + sv); c = ((dv + sv) >> W) != 0; end
      default: begin res = W'(dv - sv); c = (dv >= sv); end
    endcase
    z = (res == '0);
  endfunction

  task automatic preload(input logic [W-1:0] y, input logic [W-1:0] x);
    @(negedge clk);
    ld_y = y; ld_x = x; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // Issue one instruction from IDLE and observe 15 cycles after acceptance.
  task automatic run_instr(input logic [1:0] o, input logic d, input logic [W-1:0] im,
                           output int nrdy, output int nsh, output int ndone,
                           output logic c, output logic z);
    nrdy = 0; nsh = 0; ndone = 0; c = 1'bx; z = 1'bx;
    @(negedge clk);
    op = o; dst = d; imm = im; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    op = ~o; dst = ~d; imm = ~im;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (!ready) nrdy++;
      if (gshift) nsh++;
      if (done) begin
        ndone++;
        c = carry;
        z = zero;
      end
    end
  endtask

  task automatic check_op(input string name, input logic [1:0] o, input logic d,
                          input logic [W-1:0] y0, input logic [W-1:0] x0,
                          input logic [W-1:0] im);
    logic [W-1:0] exp_res, res, other, exp_other;
    logic         ec, ez, c, z;
    int           nrdy, nsh, ndone;
    preload(y0, x0);
    model(o, d ? x0 : y0, d ? y0 : x0, im, exp_res, ec, ez);
    exp_other = d ? y0 : x0;
    run_instr(o, d, im, nrdy, nsh, ndone, c, z);
    res   = d ? rx : ry;
    other = d ? ry : rx;
    tests++;
    if (res !== exp_res) begin
      fails++;
      $display("FAIL %s result: got %h expected %h", name, res, exp_res);
    end
    tests++;
    if (other !== exp_other) begin
      fails++;
      $display("FAIL %s source: got %h expected %h", name, other, exp_other);
    end
    tests++;
    if ({ndone, nsh, nrdy} !== {32'd1, 32'(W), 32'(W + 1)}) begin
      fails++;
      $display("FAIL %s timing: done=%0d shift=%0d notready=%0d expected 1/%0d/%0d",
               name, ndone, nsh, nrdy, W, W + 1);
    end
    tests++;
    if ({c, z} !== {ec, ez}) begin
      fails++;
      $display("FAIL %s flags: carry=%b zero=%b expected %b %b", name, c, z, ec, ez);
    end
    tests++;
    if ({carry, zero} !== {ec, ez}) begin
      fails++;
      $display("FAIL %s held flags: carry=%b zero=%b expected %b %b", name, carry, zero, ec, ez);
    end
  endtask

  task automatic test_reset;
    #1;
    tests++;
    if ({ready, done, carry, zero, gshift, gwrite, gaddr} !== 7'b1000000) begin
      fails++;
      $display("FAIL reset outputs: got %b expected 1000000",
               {ready, done, carry, zero, gshift, gwrite, gaddr});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    check_op("ld_a5", 2'b00, 1'b1, 8'h33, 8'h00, 8'hA5);
    check_op("add_3c_5a", 2'b10, 1'b0, 8'h5A, 8'h3C, 8'h00);
    check_op("add_wrap", 2'b10, 1'b0, 8'hFF, 8'h01, 8'h00);
    check_op("sub_eq", 2'b11, 1'b1, 8'h10, 8'h10, 8'h00);
    check_op("sub_borrow", 2'b11, 1'b1, 8'h01, 8'h00, 8'h00);
    check_op("clr", 2'b01, 1'b1, 8'h77, 8'hC3, 8'h00);
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++)
      check_op("random", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               W'($urandom), W'($urandom), W'($urandom));
  endtask

  task automatic test_back_to_back;
    int acc = 0, c1 = -1, c2 = -1, ndone = 0;
    logic [W-1:0] exp_y, imm2;
    logic ec, ez;
    imm2 = W'($urandom);
    preload(8'h21, 8'h0F);
    model(2'b10, 8'h21, 8'h0F, 8'h00, exp_y, ec, ez);
    @(negedge clk);
    op = 2'b10; dst = 1'b0; imm = '0; valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clk);
      if (done) ndone++;
      if (ready && valid) begin
        acc++;
        @(posedge clk);
        #1;
        if (acc == 1) begin
          c1 = k;
          op = 2'b00; dst = 1'b1; imm = imm2;
        end else begin
          c2 = k;
          valid = 1'b0;
        end
      end
    end
    valid = 1'b0;
    tests++;
    if (c2 - c1 !== W + 2) begin
      fails++;
      $display("FAIL b2b accept gap: got %0d expected %0d", c2 - c1, W + 2);
    end
    tests++;
    if (ndone !== 2) begin
      fails++;
      $display("FAIL b2b done count: got %0d expected 2", ndone);
    end
    tests++;
    if ({ry, rx} !== {exp_y, imm2}) begin
      fails++;
      $display("FAIL b2b results: ry=%h rx=%h expected %h %h", ry, rx, exp_y, imm2);
    end
  endtask

  task automatic test_reset_mid_run;
    int ndone = 0, nsh = 0;
    logic [W-1:0] exp_res;
    logic ec, ez, c, z;
    int nrdy, nsh2, nd2;
    preload(8'h5A, 8'h3C);
    @(negedge clk);
    op = 2'b10; dst = 1'b0; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    for (int k = 0; k < 20 && nsh < 4; k++) begin
      @(negedge clk);
      if (gshift) nsh++;
      if (done) ndone++;
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({ready, done, carry, zero, gshift, gwrite, gaddr} !== 7'b1000000) begin
      fails++;
      $display("FAIL midrun reset outputs: got %b expected 1000000",
               {ready, done, carry, zero, gshift, gwrite, gaddr});
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 1) rst = 1'b0;
      if (done) ndone++;
    end
    tests++;
    if (ndone !== 0) begin
      fails++;
      $display("FAIL midrun done count: got %0d expected 0", ndone);
    end
    model(2'b01, ry, rx, 8'h00, exp_res, ec, ez);
    run_instr(2'b01, 1'b0, 8'h00, nrdy, nsh2, nd2, c, z);
    tests++;
    if ({ry, c, z, nd2} !== {exp_res, ec, ez, 32'd1}) begin
      fails++;
      $display("FAIL midrun clr: ry=%h carry=%b zero=%b done=%0d expected %h %b %b 1",
               ry, c, z, nd2, exp_res, ec, ez);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
